// File: rtl/cdb_arbiter_if.sv
// Writeback packet type shared by the functional units and the CDB arbiter,
// plus the request/grant/broadcast bundle between them.
package cdb_pkg;

    typedef struct packed {
        logic        is_valid;
        logic [5:0]  dest_tag;
        logic [31:0] result;
    } writeback_packet_t;

endpackage

// The units drive the request side (master). The arbiter grants and
// broadcasts (slave).
interface cdb_arbiter_if
    import cdb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int NUM_CDB = 2
);

    writeback_packet_t [NUM_REQ-1:0] req_packet;
    logic              [NUM_REQ-1:0] req_gnt;
    writeback_packet_t [NUM_CDB-1:0] cdb_out;

    modport master (
        output req_packet,
        input  req_gnt,
        input  cdb_out
    );

    modport slave (
        input  req_packet,
        output req_gnt,
        output cdb_out
    );

endinterface

// File: rtl/cdb_arbiter.sv
// CDB write-port arbiter. Each cycle it grants up to NUM_CDB of the valid
// functional-unit results. It scans the units in rotating round-robin order
// and copies the granted packets, unmodified, onto the CDB ports in scan order.
// Per-unit saturating stall counters record the cycles a unit waited.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int NUM_CDB        = 2,
    parameter int STALL_CNT_BITS = 16
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      flush,
    cdb_arbiter_if.slave                              bus,
    output logic [NUM_REQ-1:0][STALL_CNT_BITS-1:0]    stall_cnt,
    input  logic                                      stall_clr
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Position j of the scan maps to unit (base + j) mod NUM_REQ. This wraps
    // correctly for non-power-of-two unit counts.
    function automatic int scanIdx(int base, int j);
        return (base + j) % NUM_REQ;
    endfunction

    logic [PTR_W-1:0]                           rr_q;
    logic [PTR_W-1:0]                           rr_d;
    logic [NUM_REQ-1:0]                         gnt;
    logic [NUM_REQ-1:0]                         scanGnt;
    writeback_packet_t [NUM_REQ-1:0]            scanPkt;
    writeback_packet_t [NUM_CDB-1:0]            cdbOut;
    logic [NUM_REQ-1:0][STALL_CNT_BITS-1:0]     stall_q;
    int                                         grantCnt;
    int                                         nextPtr;

    // Rotate the requests into scan order. Grant the first NUM_CDB valid ones
    // in that order and send the k-th grant to port k. Then rotate the grants
    // back to unit order. Everything is suppressed during reset and flush.
    always_comb begin
        gnt      = '0;
        scanGnt  = '0;
        scanPkt  = '0;
        cdbOut   = '0;
        grantCnt = 0;
        nextPtr  = int'(rr_q);
        for (int j = 0; j < NUM_REQ; j++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == scanIdx(int'(rr_q), j)) begin
                    scanPkt[j] = bus.req_packet[i];
                end
            end
        end
        if (rst_n && !flush) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (scanPkt[j].is_valid && (grantCnt < NUM_CDB)) begin
                    scanGnt[j] = 1'b1;
                    for (int k = 0; k < NUM_CDB; k++) begin
                        if (k == grantCnt) begin
                            cdbOut[k] = scanPkt[j];
                        end
                    end
                    grantCnt = grantCnt + 1;
                    nextPtr  = scanIdx(int'(rr_q), j + 1);
                end
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == scanIdx(int'(rr_q), j)) begin
                    gnt[i] = scanGnt[j];
                end
            end
        end
        rr_d = PTR_W'(nextPtr);
    end

    // The round-robin pointer moves to the unit just past the last grant.
    // It holds when nothing is granted, which includes every flush cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

    // Stall counters count cycles a unit was valid but not granted. They
    // saturate rather than wrap, and a clear overrides a pending increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (stall_clr) begin
                    stall_q[i] <= '0;
                end else if (bus.req_packet[i].is_valid && !gnt[i] && !flush &&
                             (stall_q[i] != {STALL_CNT_BITS{1'b1}})) begin
                    stall_q[i] <= stall_q[i] + 1'b1;
                end
            end
        end
    end

    assign bus.req_gnt = gnt;
    assign bus.cdb_out = cdbOut;
    assign stall_cnt   = stall_q;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Shares the common data bus (CDB) write ports among the execute-stage functional units (ALU, branch, LSU, MDU). Each unit holds a registered writeback_packet_t and keeps it until granted. This block grants up to NUM_CDB requesters per cycle using rotating round-robin priority and drives the granted packets onto the CDB ports. It also keeps saturating per-requester stall counters for performance analysis.

Parameters:
NUM_REQ, 4, number of requesting functional units (≥2)
NUM_CDB, 2, number of CDB write ports per cycle (1..NUM_REQ)
STALL_CNT_BITS, 16, width of each per-requester stall counter

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  pipeline flush, synchronous
req_packet  input  writeback_packet_t[NUM_REQ]  unit result registers; request = req_packet[i].is_valid
req_gnt  output  [NUM_REQ]  grant; unit advances its output register at this edge
cdb_out  output  writeback_packet_t[NUM_CDB]  CDB broadcast packets
stall_cnt  output  [NUM_REQ][STALL_CNT_BITS]  cycles each unit was valid but not granted
stall_clr  input  1  synchronous clear of all stall_cnt

Behaviour:
- Grant is combinational in the same cycle as the request. Unit-side latency: a result valid in cycle N and granted in N is broadcast in N and retired at edge N+1.
- State:
  - rr_ptr: $clog2(NUM_REQ) bits, reset 0.
  - stall_cnt[NUM_REQ]: reset 0.
- Scan order: circular, starting at rr_ptr: rr_ptr, rr_ptr+1, …, wrapping mod NUM_REQ.
- Grant rule:
  - The first NUM_CDB valid requesters in scan order are granted.
  - The k-th granted requester in scan order drives cdb_out[k].
  - Unused cdb_out[k] = '0, which makes is_valid = 0.
- A requester with is_valid = 0 is never granted.
- The number of grants equals min(valid count, NUM_CDB).
- cdb_out[k] is a bit-exact copy of the granted req_packet. The arbiter never modifies dest_tag or result.
- rr_ptr update at each edge:
  - If ≥1 grant: rr_ptr ← (index of last grant in scan order + 1) mod NUM_REQ.
  - If 0 grants: rr_ptr holds.
  - Non-power-of-two NUM_REQ must wrap correctly.
- Fairness guarantee: a continuously valid requester is granted within ceil(NUM_REQ/NUM_CDB) cycles.
- flush = 1:
  - req_gnt = 0; all cdb_out = '0.
  - rr_ptr holds.
  - stall_cnt does not increment.
  - Units clear themselves on flush, so nothing is lost.
- stall_cnt[i] per edge:
  - If stall_clr: ← 0. stall_clr has priority over increment.
  - Else if req_packet[i].is_valid && !req_gnt[i] && !flush: increment, saturating at all-ones (no wrap).
  - Else: hold.
- Reset (rst_n low, asynchronous):
  - rr_ptr = 0; stall_cnt = 0.
  - req_gnt = 0 and cdb_out = '0 while rst_n = 0, regardless of inputs.
  - Deassertion mid-traffic: arbitration resumes from rr_ptr = 0 in the first cycle with rst_n = 1.
- No combinational path from req_gnt back to req_packet within this block.
- Protocol assertion in the bench: a valid, ungranted req_packet must be stable the next cycle.

Test Plan:
- Reset, then all 4 requesters valid continuously with NUM_CDB = 2 -> gnt 0011, 1100, 0011, 1100. Order on cdb_out per grant: {0→port0, 1→port1}, {2→port0, 3→port1}, repeating.
- rr_ptr = 3 (after grants {1,2}), then requesters 0 and 3 valid -> gnt 1001, cdb_out[0] = req 3, cdb_out[1] = req 0, next rr_ptr = 1.
- Only requester 2 valid, dest_tag = 5, result = 0xDEADBEEF -> gnt 0100, cdb_out[0] = {5, 0xDEADBEEF, valid}, cdb_out[1].is_valid = 0, rr_ptr ← 3.
- All valid with flush asserted for 1 cycle -> gnt 0000, both ports invalid, rr_ptr and stall_cnt unchanged. The following cycle resumes from the held rr_ptr.
- Requester 3 valid for 3 cycles while 0/1/2 are granted first -> stall_cnt[3] = 1 then stops. Assert stall_clr with increment pending -> 0. Force STALL_CNT_BITS = 2 and hold stalled for 5 cycles -> saturates at 3.
- Pull rst_n low asynchronously mid-cycle with all requesters valid -> req_gnt and cdb_out go 0 immediately, rr_ptr = 0. After release -> first grant is 0011.
